// File: rtl/es_pkg.sv
// Shared types for the I/O responder: FSM state encoding and the
// entradaSaidaControl operation codes driven by the control unit.
package es_pkg;

   typedef enum logic [1:0] {
      OCIOSO       = 2'b00,
      ESPERA_PRESS = 2'b01,
      ESPERA_SOLTA = 2'b10,
      LIBERA       = 2'b11
   } estado_t;

   typedef logic [1:0] es_codigo_t;

   // Code 2'b11 is reserved and decodes like ES_NENHUM.
   localparam es_codigo_t ES_NENHUM = 2'b00;
   localparam es_codigo_t ES_OUT    = 2'b01;
   localparam es_codigo_t ES_IN     = 2'b10;

endpackage

// File: rtl/debounce_botao.sv
// Confirm-button conditioner: two-flop synchronizer followed by a saturating
// stability counter; the level flips only after DEBOUNCE_CYCLES mismatching cycles.
module debounce_botao #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic bruto,
   output logic nivel,
   output logic subida,
   output logic descida
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sinc;
   logic [CW-1:0] cont;
   logic          vira;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sinc <= '0;
      end else begin
         sinc <= {sinc[0], bruto};
      end
   end

   // Strobes are asserted during the cycle before the edge that flips nivel,
   // so consumers act on the same edge the stable level changes.
   assign vira    = (sinc[1] != nivel) && (cont == LIMITE);
   assign subida  = vira &  sinc[1];
   assign descida = vira & ~sinc[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cont  <= '0;
         nivel <= 1'b0;
      end else if (sinc[1] == nivel) begin
         cont <= '0;
      end else if (vira) begin
         cont  <= '0;
         nivel <= sinc[1];
      end else if (cont != '1) begin
         cont <= cont + CW'(1);
      end
   end

endmodule

// File: rtl/controlador_entrada_saida.sv
// Far-end responder of the in/out/pause handshake: stalls the PC until the
// operator confirms, captures switches for `in`, and latches `out` operands.
module controlador_entrada_saida
   import es_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int SW_WIDTH        = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  status,
   input  logic [1:0]            entradaSaidaControl,
   input  logic [DATA_WIDTH-1:0] dadoSaida,
   input  logic [SW_WIDTH-1:0]   switches,
   input  logic                  botaoConfirma,
   output logic [DATA_WIDTH-1:0] dadoEntrada,
   output logic [DATA_WIDTH-1:0] displayOut,
   output logic                  outValid,
   output logic                  liberaPC,
   output logic                  aguardando
);

   estado_t             estado, proximo;
   logic [SW_WIDTH-1:0] sw_meta, sw_sinc;
   logic                btn_estavel, btn_sobe, btn_desce;
   logic                soltou;
   logic                eh_entrada;
   logic                captura;

   debounce_botao #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .bruto   (botaoConfirma),
      .nivel   (btn_estavel),
      .subida  (btn_sobe),
      .descida (btn_desce)
   );

   // soltou trails the fall strobe by one edge: LIBERA is entered one cycle
   // after btn_estavel has settled low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sw_meta <= '0;
         sw_sinc <= '0;
         soltou  <= 1'b0;
      end else begin
         sw_meta <= switches;
         sw_sinc <= sw_meta;
         soltou  <= btn_desce;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado     <= OCIOSO;
         eh_entrada <= 1'b0;
      end else begin
         estado <= proximo;
         if (estado == OCIOSO && status) begin
            eh_entrada <= (entradaSaidaControl == ES_IN);
         end
      end
   end

   // NOTE: defaults first keep this block latch-free on every path.
   always_comb begin
      proximo = estado;
      captura = 1'b0;
      case (estado)
         OCIOSO: begin
            if (status) proximo = ESPERA_PRESS;
         end
         ESPERA_PRESS: begin
            // Only a fresh rise counts, so a button held on entry never confirms.
            if (btn_sobe) begin
               proximo = ESPERA_SOLTA;
               captura = eh_entrada;
            end
         end
         ESPERA_SOLTA: begin
            if (soltou) proximo = LIBERA;
         end
         LIBERA: begin
            proximo = OCIOSO;
         end
         default: proximo = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dadoEntrada <= '0;
      end else if (captura) begin
         dadoEntrada <= DATA_WIDTH'(sw_sinc);
      end
   end

   // The display path ignores the FSM entirely.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         displayOut <= '0;
         outValid   <= 1'b0;
      end else begin
         outValid <= (entradaSaidaControl == ES_OUT);
         if (entradaSaidaControl == ES_OUT) begin
            displayOut <= dadoSaida;
         end
      end
   end

   assign liberaPC   = (estado == LIBERA);
   assign aguardando = (estado != OCIOSO);

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Scoreboard bench for controlador_entrada_saida with DEBOUNCE_CYCLES = 4:
// stimulus pushes expected liberaPC / outValid events, a monitor pops and compares.
module tb_controlador_entrada_saida;

   localparam int DW = 32;
   localparam int SW = 16;
   localparam int DB = 4;
   // Raw release to liberaPC: 2 sync + DB debounce + 1 to enter LIBERA.
   localparam int LAT_SOLTA = 2 + DB + 1;

   typedef struct {
      logic [DW-1:0] dado;
      int            ciclo;
   } esperado_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          status = 1'b0;
   logic [1:0]    entradaSaidaControl = 2'b00;
   logic [DW-1:0] dadoSaida = '0;
   logic [SW-1:0] switches = '0;
   logic          botaoConfirma = 1'b0;
   logic [DW-1:0] dadoEntrada;
   logic [DW-1:0] displayOut;
   logic          outValid;
   logic          liberaPC;
   logic          aguardando;

   esperado_t fila_libera[$];
   esperado_t fila_out[$];
   int        ciclo = 0;
   int        n_checks = 0;
   int        n_falhas = 0;

   controlador_entrada_saida #(
      .DATA_WIDTH      (DW),
      .SW_WIDTH        (SW),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .status              (status),
      .entradaSaidaControl (entradaSaidaControl),
      .dadoSaida           (dadoSaida),
      .switches            (switches),
      .botaoConfirma       (botaoConfirma),
      .dadoEntrada         (dadoEntrada),
      .displayOut          (displayOut),
      .outValid            (outValid),
      .liberaPC            (liberaPC),
      .aguardando          (aguardando)
   );

   always #5 clock = ~clock;
   always @(posedge clock) ciclo <= ciclo + 1;

   task automatic check(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
      n_checks++;
      if (obtido !== esperado) begin
         n_falhas++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nome, obtido, esperado, ciclo);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Scoreboard monitor: every pulse must match the oldest pending expectation.
   always @(negedge clock) begin
      if (reset) begin
         if (liberaPC) begin
            check("libera_expected", 64'(fila_libera.size() != 0), 64'd1);
            if (fila_libera.size() != 0) begin
               esperado_t e;
               e = fila_libera.pop_front();
               check("libera_dadoEntrada", 64'(dadoEntrada), 64'(e.dado));
               check("libera_cycle", 64'(ciclo), 64'(e.ciclo));
            end
         end
         if (outValid) begin
            check("out_expected", 64'(fila_out.size() != 0), 64'd1);
            if (fila_out.size() != 0) begin
               esperado_t e;
               e = fila_out.pop_front();
               check("out_displayOut", 64'(displayOut), 64'(e.dado));
               check("out_cycle", 64'(ciclo), 64'(e.ciclo));
            end
         end
      end
   end

   task automatic espera_libera();
      bit visto = 1'b0;
      for (int i = 0; i < 40 && !visto; i++) begin
         @(negedge clock);
         if (liberaPC) visto = 1'b1;
      end
      check("libera_seen", 64'(visto), 64'd1);
      // PC advances on the edge after LIBERA; the stall request drops then.
      tick(1);
      status = 1'b0;
      entradaSaidaControl = 2'b00;
   endtask

   task automatic press_release(input int dur, input logic [DW-1:0] esperado);
      esperado_t e;
      botaoConfirma = 1'b1;
      tick(dur);
      botaoConfirma = 1'b0;
      e.dado  = esperado;
      e.ciclo = ciclo + LAT_SOLTA;
      fila_libera.push_back(e);
      espera_libera();
   endtask

   task automatic pulso_out(input logic [DW-1:0] valor);
      esperado_t e;
      entradaSaidaControl = 2'b01;
      dadoSaida = valor;
      e.dado  = valor;
      e.ciclo = ciclo + 1;
      fila_out.push_back(e);
      tick(1);
      entradaSaidaControl = 2'b00;
      dadoSaida = '0;
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_dadoEntrada", 64'(dadoEntrada), 64'd0);
      check("rst_displayOut", 64'(displayOut), 64'd0);
      check("rst_outValid", 64'(outValid), 64'd0);
      check("rst_liberaPC", 64'(liberaPC), 64'd0);
      check("rst_aguardando", 64'(aguardando), 64'd0);
      tick(2);
      reset = 1'b1;
      tick(2);

      // in: happy path
      switches = 16'h00A5;
      entradaSaidaControl = 2'b10;
      status = 1'b1;
      tick(1);
      check("in_aguardando", 64'(aguardando), 64'd1);
      press_release(10, 32'h0000_00A5);
      tick(1);
      check("in_back_idle", 64'(aguardando), 64'd0);

      // out while idle
      pulso_out(32'hDEAD_BEEF);
      tick(3);

      // Bounce rejection, then a stable press captures 1234
      switches = 16'h1234;
      entradaSaidaControl = 2'b10;
      status = 1'b1;
      tick(1);
      for (int i = 0; i < 10; i++) begin
         botaoConfirma = (i % 2 == 0);
         tick(2);
      end
      botaoConfirma = 1'b0;
      tick(8);
      check("bounce_no_capture", 64'(dadoEntrada), 64'h0000_00A5);
      check("bounce_still_waiting", 64'(aguardando), 64'd1);
      press_release(8, 32'h0000_1234);
      tick(2);

      // pause leaves dadoEntrada alone; out works while stalled
      entradaSaidaControl = 2'b00;
      status = 1'b1;
      switches = 16'hFFFF;
      tick(1);
      check("pause_aguardando", 64'(aguardando), 64'd1);
      pulso_out(32'hCAFE_F00D);
      tick(1);
      check("out_during_stall_aguardando", 64'(aguardando), 64'd1);
      press_release(8, 32'h0000_1234);
      tick(2);

      // Held button never auto-confirms
      botaoConfirma = 1'b1;
      tick(10);
      switches = 16'h0F0F;
      entradaSaidaControl = 2'b10;
      status = 1'b1;
      tick(4);
      check("held_no_capture", 64'(dadoEntrada), 64'h0000_1234);
      switches = 16'h5A5A;
      botaoConfirma = 1'b0;
      tick(10);
      check("held_released_waiting", 64'(aguardando), 64'd1);
      check("held_released_no_capture", 64'(dadoEntrada), 64'h0000_1234);
      switches = 16'h00C3;
      tick(3);
      press_release(8, 32'h0000_00C3);
      tick(2);

      // Reset asserted mid-sequence in ESPERA_SOLTA
      switches = 16'h7777;
      entradaSaidaControl = 2'b10;
      status = 1'b1;
      tick(1);
      botaoConfirma = 1'b1;
      tick(8);
      check("midrst_captured", 64'(dadoEntrada), 64'h0000_7777);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_dadoEntrada", 64'(dadoEntrada), 64'd0);
      check("midrst_displayOut", 64'(displayOut), 64'd0);
      check("midrst_outValid", 64'(outValid), 64'd0);
      check("midrst_liberaPC", 64'(liberaPC), 64'd0);
      check("midrst_aguardando", 64'(aguardando), 64'd0);
      botaoConfirma = 1'b0;
      status = 1'b0;
      entradaSaidaControl = 2'b00;
      tick(2);
      reset = 1'b1;
      tick(10);
      check("midrst_stays_idle", 64'(aguardando), 64'd0);
      switches = 16'h0042;
      entradaSaidaControl = 2'b10;
      status = 1'b1;
      tick(1);
      check("midrst_fresh_status", 64'(aguardando), 64'd1);
      press_release(8, 32'h0000_0042);
      tick(5);

      check("libera_queue_empty", 64'(fila_libera.size()), 64'd0);
      check("out_queue_empty", 64'(fila_out.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_falhas);
      $finish;
   end

endmodule

// File: doc/controlador_entrada_saida.md
# controlador_entrada_saida

Sequential I/O responder at the far end of the control unit's `in`/`out`/`pause` handshake. When the control unit raises `status` (stall) for `in` or `pause`, this block holds the processor, waits for a debounced operator confirm press and release, captures the switch value for `in`, and pulses `liberaPC` so the PC advances. For `out`, it latches the register operand onto the display bus. It sits beside the control unit and the register-file write mux; `dadoEntrada` feeds the write-data mux input selected by `dadoRegControl = 3'b100`.

## Interface
- `DATA_WIDTH`, 32: processor word width.
- `SW_WIDTH`, 16: number of physical switches, ≤ `DATA_WIDTH`.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required for a button level change; ≥ 2.

- `clock` in 1: single system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low; asserted (0) forces reset state immediately.
- `status` in 1: stall request from the control unit (1 for `in`, `pause`).
- `entradaSaidaControl` in 2: 00 none/pause, 01 out, 10 in, 11 reserved (treated as 00).
- `dadoSaida` in DATA_WIDTH: register operand for `out`.
- `switches` in SW_WIDTH: raw switch levels, asynchronous.
- `botaoConfirma` in 1: raw confirm button, active-high, asynchronous, bouncy.
- `dadoEntrada` out DATA_WIDTH: captured input word, zero-extended from `switches`.
- `displayOut` out DATA_WIDTH: last `out` value.
- `outValid` out 1: one-cycle pulse per cycle in which `out` is latched.
- `liberaPC` out 1: one-cycle release; PC enable for the stalled instruction.
- `aguardando` out 1: high while the FSM is outside OCIOSO; drives the wait LED.

## Operation
- Button path: two-flop synchronizer, then a debouncer. `btnEstavel` changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any mismatch-free cycle resets the counter. The counter is $clog2(DEBOUNCE_CYCLES+1) bits, saturating, no wrap.
- Switches: two-flop synchronized. They are sampled only at capture.
- FSM states:
  - OCIOSO: if `status`=1, go to ESPERA_PRESS and record `ehEntrada` = (`entradaSaidaControl`==10).
  - ESPERA_PRESS: on the cycle `btnEstavel` rises to 1, go to ESPERA_SOLTA. If `ehEntrada`, load `dadoEntrada` ← {zeros, synced switches} in the same edge.
  - ESPERA_SOLTA: on `btnEstavel` falling to 0, go to LIBERA.
  - LIBERA: `liberaPC`=1 for this cycle only, then unconditionally go to OCIOSO.
- `pause` runs the same sequence; `dadoEntrada` is left unchanged.
- `out`: in any state, `entradaSaidaControl`==01 loads `displayOut` ← `dadoSaida` and sets `outValid`=1 at the next edge. `outValid` deasserts the following cycle unless 01 is still present.
- `status` deasserting mid-sequence (not legal from the control unit) is ignored; the sequence completes.
- If the button is already stably pressed on entry to ESPERA_PRESS, no rising edge is seen. The FSM waits for release and a new press, so a held button never auto-confirms.
- `dadoEntrada` holds its value until the next `in` capture.

## Timing
- Reset values: FSM = OCIOSO; `dadoEntrada`, `displayOut` = 0; `outValid`, `liberaPC`, `aguardando` = 0; debouncer counter = 0; `btnEstavel` = 0; synchronizers = 0.
- Stall entry: OCIOSO → ESPERA_PRESS one edge after `status` is sampled high. `aguardando` rises on that edge.
- Press latency: raw press to `btnEstavel`=1 is 2 (sync) + `DEBOUNCE_CYCLES` cycles. The capture happens on that same edge.
- Release to `liberaPC`: 2 + `DEBOUNCE_CYCLES` cycles to `btnEstavel`=0, then 1 cycle to enter LIBERA.
- `liberaPC` is registered, high for exactly one cycle. `dadoEntrada` is stable for at least `DEBOUNCE_CYCLES` cycles before and during that cycle, so the register write completes on the same edge.
- The FSM is back in OCIOSO one edge after LIBERA. The PC has advanced by then, so the old `status` is never re-sampled.
- `out` latency: one edge, fully independent of the FSM.

## Structure
- Package `es_pkg`: state enum {OCIOSO, ESPERA_PRESS, ESPERA_SOLTA, LIBERA} as 2-bit encoding 00/01/10/11.
- Package `es_pkg` also holds the `entradaSaidaControl` codes ES_NENHUM=00, ES_OUT=01, ES_IN=10.
- One sub-module: `debounce_botao` (synchronizer + counter, parameter `DEBOUNCE_CYCLES`, outputs level and rise/fall strobes).

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- Reset mid-operation: reset asserted while in ESPERA_SOLTA → all outputs 0 and FSM in OCIOSO immediately; after release, a fresh `status` is required.
- `in` happy path: `status`=1, code 10, switches=16'h00A5; clean press 10 cycles then release → `dadoEntrada`=32'h000000A5 and exactly one `liberaPC` pulse, 7 cycles after the raw release.
- Bounce rejection: the button toggles every 2 cycles for 20 cycles → no capture and no `liberaPC`; a stable press then succeeds.
- `pause`: `status`=1, code 00, `dadoEntrada` preset to 32'h1234 → after press and release, `liberaPC` pulses and `dadoEntrada` still equals 32'h1234.
- `out`: code 01 for one cycle with `dadoSaida`=32'hDEADBEEF → next cycle `displayOut`=32'hDEADBEEF and `outValid` is a 1-cycle pulse. The same behaviour holds while the FSM is in ESPERA_PRESS.
- Held button: button stably pressed before `status` rises → no capture until release and re-press; the capture takes the switches value at the re-press.
